keypad_scanner: RTL and testbench

Upstream stage of the 4x4 keypad decoder. It drives the keypad columns one-hot, synchronises and debounces the raw row lines, and locks the scan on a confirmed key. It presents a stable col/fil pair that the decoder turns into a key code. fil is nonzero only while a single debounced key is held, so the decoder's "no key" default never overwrites its stored code.

---
 rtl/keypad_scanner.sv | 162 ++++++++++++++++
 tb/tb_keypad_scanner.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// 4x4 keypad column scanner with row synchroniser, tick-sampled debounce and scan lock.
// Optional auto-repeat of key_press while a key is held: define KEY_REPEAT_EN.
module keypad_scanner #(
  parameter int unsigned SETTLE      = 1000,
  parameter int unsigned DEB_SAMPLES = 4,
  parameter int unsigned REPEAT_CYC  = 250000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_in,
  output logic [3:0] col,
  output logic [3:0] fil,
  output logic       key_press,
  output logic       key_held
);

  localparam int unsigned TickW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int unsigned CntW  = $clog2(DEB_SAMPLES + 1);
  localparam logic [TickW-1:0] TickLast = TickW'(SETTLE - 1);
  localparam logic [CntW-1:0]  CntLast  = CntW'(DEB_SAMPLES - 1);
  localparam logic [CntW-1:0]  CntOne   = CntW'(1);

  typedef enum logic [1:0] {StScan, StDebPress, StHeld, StDebRel} state_e;

  logic [3:0]       r_sync1;
  logic [3:0]       r_row_s;
  logic [TickW-1:0] r_tick_cnt;
  logic             w_tick;
  state_e           r_state;
  logic [CntW-1:0]  r_cnt;
  logic [3:0]       r_pat;
  logic [3:0]       r_col;
  logic [3:0]       r_fil;
  logic             r_key_press;
  logic             r_key_held;
  logic [3:0]       w_col_next;
  logic             w_pat_onehot;

`ifdef KEY_REPEAT_EN
  localparam int unsigned RepW = (REPEAT_CYC > 1) ? $clog2(REPEAT_CYC) : 1;
  localparam logic [RepW-1:0] RepLast = RepW'(REPEAT_CYC - 1);
  logic [RepW-1:0] r_rep_cnt;
  logic            w_rep_run;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 4'b0000;
      r_row_s <= 4'b0000;
    end else begin
      r_sync1 <= row_in;
      r_row_s <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + TickW'(1);
    end
  end

  assign w_tick       = (r_tick_cnt == TickLast);
  assign w_col_next   = {r_col[2:0], r_col[3]};
  assign w_pat_onehot = $onehot(r_pat);

`ifdef KEY_REPEAT_EN
  // Repeat runs only while a valid key stays in HELD; leaving HELD restarts it from 0.
  assign w_rep_run = (r_state == StHeld) && (r_fil != 4'b0000) &&
                     !(w_tick && (r_row_s == 4'b0000));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StScan;
      r_cnt       <= '0;
      r_pat       <= 4'b0000;
      r_col       <= 4'b0001;
      r_fil       <= 4'b0000;
      r_key_press <= 1'b0;
      r_key_held  <= 1'b0;
`ifdef KEY_REPEAT_EN
      r_rep_cnt   <= '0;
`endif
    end else begin
      r_key_press <= 1'b0;
      if (w_tick) begin
        unique case (r_state)
          StScan: begin
            if (r_row_s == 4'b0000) begin
              r_col <= w_col_next;
            end else begin
              r_pat   <= r_row_s;
              r_cnt   <= CntOne;
              r_state <= StDebPress;
            end
          end
          StDebPress: begin
            if (r_row_s == r_pat) begin
              if (r_cnt == CntLast) begin
                r_state <= StHeld;
                // Ghost/multi-key patterns lock the scan but never reach the decoder.
                if (w_pat_onehot) begin
                  r_fil       <= r_pat;
                  r_key_held  <= 1'b1;
                  r_key_press <= 1'b1;
                end
              end else begin
                r_cnt <= r_cnt + CntOne;
              end
            end else begin
              r_state <= StScan;
              r_col   <= w_col_next;
            end
          end
          StHeld: begin
            if (r_row_s == 4'b0000) begin
              r_cnt   <= CntOne;
              r_state <= StDebRel;
            end
          end
          StDebRel: begin
            if (r_row_s == 4'b0000) begin
              if (r_cnt == CntLast) begin
                r_state    <= StScan;
                r_fil      <= 4'b0000;
                r_key_held <= 1'b0;
                r_col      <= w_col_next;
              end else begin
                r_cnt <= r_cnt + CntOne;
              end
            end else begin
              r_state <= StHeld;
            end
          end
          default: r_state <= StScan;
        endcase
      end
`ifdef KEY_REPEAT_EN
      if (w_rep_run) begin
        if (r_rep_cnt == RepLast) begin
          r_rep_cnt   <= '0;
          r_key_press <= 1'b1;
        end else begin
          r_rep_cnt <= r_rep_cnt + RepW'(1);
        end
      end else begin
        r_rep_cnt <= '0;
      end
`endif
    end
  end

  assign col       = r_col;
  assign fil       = r_fil;
  assign key_press = r_key_press;
  assign key_held  = r_key_held;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner (SETTLE=4, DEB_SAMPLES=3, REPEAT_CYC=20).
// Expected key_press events are queued with the stimulus and checked by a strobe monitor.
module tb_keypad_scanner;

  logic       clk;
  logic       rst_n;
  logic [3:0] row_in;
  logic [3:0] col;
  logic [3:0] fil;
  logic       key_press;
  logic       key_held;

  int n_cmp;
  int n_err;
  logic [3:0] exp_q[$];

  keypad_scanner #(
    .SETTLE      (4),
    .DEB_SAMPLES (3),
    .REPEAT_CYC  (20)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .row_in    (row_in),
    .col       (col),
    .fil       (fil),
    .key_press (key_press),
    .key_held  (key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every strobe must match a queued expectation; unexpected strobes are failures.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && key_press === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL strobe_unexpected: key_press=1 fil=%b, required no strobe", fil);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        if (fil !== e) begin
          n_err++;
          $display("FAIL strobe_fil: fil=%b, required %b", fil, e);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst_n  = 1'b0;
    row_in = 4'b0000;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({col, fil, key_press, key_held} !== {4'b0001, 4'b0000, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_values: col=%b fil=%b press=%b held=%b, required 0001 0000 0 0",
               col, fil, key_press, key_held);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_idle_scan();
    int bad_col;
    int bad_out;
    logic [3:0] e;
    bad_col = 0;
    bad_out = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      e = 4'b0001 << ((n / 4) % 4);
      if (col !== e) begin
        bad_col++;
        if (bad_col == 1) $display("FAIL idle_col: cycle %0d col=%b, required %b", n, col, e);
      end
      if (fil !== 4'b0000 || key_press !== 1'b0 || key_held !== 1'b0) bad_out++;
    end
    n_cmp++;
    if (bad_col != 0) n_err++;
    n_cmp++;
    if (bad_out != 0) begin
      n_err++;
      $display("FAIL idle_outputs: %0d cycles with fil/press/held nonzero, required 0", bad_out);
    end
  endtask

  task automatic test_press();
    bit seen;
    bit frozen_ok;
    int lat;
    int bad;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (col === 4'b0010) seen = 1;
    end
    n_cmp++;
    if (!seen) begin
      n_err++;
      $display("FAIL press_align: col=%b, required 0010 within 20 cycles", col);
    end
    row_in = 4'b0100;
    exp_q.push_back(4'b0100);
    seen = 0;
    frozen_ok = 1;
    lat = 0;
    while (!seen && lat < 24) begin
      @(negedge clk);
      lat++;
      if (key_press === 1'b1) seen = 1;
      if (col !== 4'b0010) frozen_ok = 0;
    end
    n_cmp++;
    if (!seen || lat != 12) begin
      n_err++;
      $display("FAIL press_latency: strobe seen=%0d after %0d cycles, required 1 after 12",
               seen, lat);
    end
    n_cmp++;
    if (fil !== 4'b0100 || key_held !== 1'b1) begin
      n_err++;
      $display("FAIL press_outputs: fil=%b held=%b, required 0100 1", fil, key_held);
    end
    n_cmp++;
    if (!frozen_ok) begin
      n_err++;
      $display("FAIL press_col_frozen: col=%b moved, required 0010", col);
    end
    bad = 0;
    repeat (12) begin
      @(negedge clk);
      if (key_press !== 1'b0 || fil !== 4'b0100 || key_held !== 1'b1 || col !== 4'b0010) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL press_hold: %0d bad cycles, required press=0 fil=0100 held=1 col=0010",
               bad);
    end
  endtask

  task automatic test_release();
    bit fell;
    int lat;
    int bad;
    row_in = 4'b0000;
    fell = 0;
    lat = 0;
    bad = 0;
    while (!fell && lat < 20) begin
      @(negedge clk);
      lat++;
      if (key_held === 1'b0) fell = 1;
      else if (fil !== 4'b0100 || col !== 4'b0010) bad++;
    end
    n_cmp++;
    if (!fell || lat != 12) begin
      n_err++;
      $display("FAIL release_latency: fell=%0d after %0d cycles, required 1 after 12", fell, lat);
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL release_hold: %0d cycles lost fil/col before release, required 0", bad);
    end
    n_cmp++;
    if (fil !== 4'b0000 || col !== 4'b0100) begin
      n_err++;
      $display("FAIL release_outputs: fil=%b col=%b, required 0000 0100", fil, col);
    end
    repeat (4) @(negedge clk);
    n_cmp++;
    if (col !== 4'b1000) begin
      n_err++;
      $display("FAIL release_rescan: col=%b, required 1000", col);
    end
  endtask

  task automatic test_bounce();
    bit seen;
    int bad;
    logic [3:0] c0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (col === 4'b0010) seen = 1;
    end
    n_cmp++;
    if (!seen) begin
      n_err++;
      $display("FAIL bounce_align: col=%b, required 0010 within 20 cycles", col);
    end
    bad = 0;
    for (int k = 0; k < 8; k++) begin
      row_in = (k % 2 == 0) ? 4'b0100 : 4'b0000;
      repeat (4) begin
        @(negedge clk);
        if (fil !== 4'b0000 || key_held !== 1'b0 || !$onehot(col)) bad++;
      end
    end
    row_in = 4'b0000;
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL bounce_outputs: %0d bad cycles, required fil=0000 held=0 col one-hot", bad);
    end
    c0 = col;
    seen = 0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      if (col !== c0) seen = 1;
    end
    n_cmp++;
    if (!seen || !$onehot(col)) begin
      n_err++;
      $display("FAIL bounce_rescan: col=%b stuck from %b, required rotation", col, c0);
    end
  endtask

  task automatic test_multi_key_and_reset();
    bit seen;
    int bad;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (col === 4'b0100) seen = 1;
    end
    n_cmp++;
    if (!seen) begin
      n_err++;
      $display("FAIL multi_align: col=%b, required 0100 within 20 cycles", col);
    end
    row_in = 4'b0110;
    bad = 0;
    repeat (36) begin
      @(negedge clk);
      if (col !== 4'b0100 || fil !== 4'b0000 || key_held !== 1'b0 || key_press !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL multi_key: %0d bad cycles, required col=0100 fil=0000 held=0 press=0",
               bad);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({col, fil, key_press, key_held} !== {4'b0001, 4'b0000, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL midreset: col=%b fil=%b press=%b held=%b, required 0001 0000 0 0",
               col, fil, key_press, key_held);
    end
    row_in = 4'b0000;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (8) begin
      @(negedge clk);
      if (key_press !== 1'b0 || key_held !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL reset_release: %0d cycles with press/held high, required 0", bad);
    end
  endtask

`ifdef KEY_REPEAT_EN
  task automatic test_repeat();
    bit seen;
    int pulses[$];
    int lat;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (col === 4'b0010) seen = 1;
    end
    row_in = 4'b0100;
    repeat (4) exp_q.push_back(4'b0100);
    seen = 0;
    lat = 0;
    while (!seen && lat < 24) begin
      @(negedge clk);
      lat++;
      if (key_press === 1'b1) seen = 1;
    end
    n_cmp++;
    if (!seen) begin
      n_err++;
      $display("FAIL repeat_confirm: no strobe within 24 cycles, required one");
    end
    for (int t = 1; t <= 70; t++) begin
      @(negedge clk);
      if (key_press === 1'b1) pulses.push_back(t);
    end
    n_cmp++;
    if (pulses.size() != 3 || pulses[0] != 20 || pulses[1] != 40 || pulses[2] != 60) begin
      n_err++;
      $display("FAIL repeat_times: %0d repeats, first at %0d, required 3 at 20/40/60",
               pulses.size(), (pulses.size() > 0) ? pulses[0] : -1);
    end
    row_in = 4'b0000;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (key_held === 1'b0) seen = 1;
    end
    n_cmp++;
    if (!seen) begin
      n_err++;
      $display("FAIL repeat_release: key_held=%b, required 0 within 20 cycles", key_held);
    end
  endtask
`endif

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    rst_n  = 1'b0;
    row_in = 4'b0000;
    test_reset();
    test_idle_scan();
    test_press();
    test_release();
    test_bounce();
    test_multi_key_and_reset();
`ifdef KEY_REPEAT_EN
    test_repeat();
`endif
    repeat (2) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d expected strobes missing, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
